uart_tx_engine: RTL
===================

// Module: uart_tx_engine
// PURPOSE
//  Serial transmitter of the UART. Pops bytes from the FWFT downstream FIFO, which the APB regmap fills,
//  and serialises each byte onto o_tx as start / data (LSB first) / optional parity / stop bits.
//  Its baud tick comes from a programmable clock divider. Its busy and done outputs feed the regmap
//  status bit and the IRQ generator.
// PARAMETERS
//  DATA_W   8   width of FIFO data word; only bits [7:0] are serialised, upper bits ignored
//  DIV_W    16  width of baud divider; bit period = (i_baud_div + 1) clocks
// PORTS
//  i_clk          in   1       APB clock (i_apb_pclk at top)
//  i_nrst         in   1       asynchronous reset, active low
//  i_enable       in   1       transmitter enable (regmap CTRL)
//  i_baud_div     in   DIV_W   clocks per bit minus 1
//  i_data_bits    in   2       0:5 1:6 2:7 3:8 data bits
//  i_stop2        in   1       0: one stop bit, 1: two stop bits
//  i_parity_en    in   1       append parity bit (only with UART_TX_PARITY_EN)
//  i_parity_odd   in   1       0: even, 1: odd parity
//  i_fifo_valid   in   1       downstream FIFO non-empty (FWFT valid)
//  i_fifo_data    in   DATA_W  FWFT head word
//  o_fifo_rd_req  out  1       one-cycle pop strobe
//  o_tx           out  1       serial line, idle high
//  o_busy         out  1       frame in progress (tx_status)
//  o_tx_done      out  1       one-cycle pulse at end of each frame
// BEHAVIOUR
//  - Reset values: o_tx=1, o_busy=0, o_tx_done=0, o_fifo_rd_req=0. FSM goes to IDLE and counters clear.
//    Reset is async, so a frame cut mid-way drives the line high immediately.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//  - IDLE, i_enable & i_fifo_valid:
//    - assert o_fifo_rd_req for that cycle only;
//    - latch i_fifo_data[7:0], i_baud_div, i_data_bits, i_stop2 and parity config;
//    - next cycle go to START with o_tx=0 and o_busy=1.
//  - Config is sampled only at frame start. Register changes mid-frame have no effect until the next frame.
//  - Baud counter loads the latched div at each bit start and decrements to 0; a bit ends when the counter is 0.
//    div=0 is legal (1 clock per bit). Each bit lasts exactly div+1 clocks.
//  - DATA shifts LSB first. The bit counter stops after N=5..8 bits.
//  - PARITY bit = ^data[N-1:0] ^ parity_odd, computed over only the N transmitted bits.
//  - STOP drives 1 for 1 or 2 bit periods.
//  - Frame length = (1 + N + P + S) * (div+1) clocks, where P = 0/1 and S = 1/2.
//  - o_tx_done pulses on the last clock of the final stop bit.
//    - If i_enable & i_fifo_valid hold in that same cycle, o_fifo_rd_req pulses with it and the FSM goes
//      straight to START. Back-to-back frames have zero idle clocks and o_busy stays 1.
//    - Otherwise the FSM goes to IDLE and o_busy=0 on the next cycle.
//  - i_enable deasserted mid-frame: the current frame completes normally and no further pop occurs.
//  - i_fifo_valid dropping mid-frame is ignored, since the data is already latched.
//  - o_fifo_rd_req is never asserted while i_fifo_valid=0, so the FIFO never underflows.
//  - o_tx is registered: no glitches, and line changes align to bit boundaries.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state, parity logic and i_parity_en / i_parity_odd are active.
//  UART_TX_PARITY_EN undefined: no PARITY state and P=0 always; i_parity_en / i_parity_odd are ignored
//  (ports kept, unused).
// TESTING
//  1. 8N1, div=3, push 0xA5. Expect:
//     - o_fifo_rd_req pulses once;
//     - o_tx reads 0,1,0,1,0,0,1,0,1,1, each held 4 clocks;
//     - 40 clocks total, o_tx_done on clock 40, o_busy falls one clock later.
//  2. Parity: 7 data bits, even parity, 2 stop, div=0, push 0x53.
//     - With the macro: bits 0,1,1,0,0,1,0,1,0,1,1 (parity=0) over 11 clocks.
//     - Without the macro: 10 clocks and no parity bit.
//  3. Back-to-back: push 0x00,0xFF with 8N1 and div=1.
//     - Second o_fifo_rd_req pulses in the same cycle as the first o_tx_done.
//     - o_tx has no idle-high gap beyond the stop bit; o_busy stays 1 for 40 clocks.
//  4. i_enable drops at clock 5 of a frame with 2 words queued.
//     - Frame 1 completes and o_tx_done pulses.
//     - No second pop occurs, o_tx stays 1, and the FIFO still holds one word.
//  5. Reset asserted mid-DATA.
//     - Same cycle: o_tx=1, o_busy=0.
//     - After release, with FIFO valid and enable: a fresh full frame starts with a START bit.
//  6. i_baud_div changed 3->7 mid-frame.
//     - Current frame keeps 4 clocks/bit; the next frame uses 8 clocks/bit.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from an FWFT FIFO and serialises start/data/[parity]/stop bits.
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
//
// state     | meaning
// ST_IDLE   | line high, waiting for enable and a FIFO word
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting data bits out LSB first
// ST_PARITY | driving the parity bit (UART_TX_PARITY_EN builds only)
// ST_STOP   | driving one or two stop bits (1)
module uart_tx_engine #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_baud_div,
  input  logic [1:0]        i_data_bits,
  input  logic              i_stop2,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_fifo_valid,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd_req,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_tx_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shift_q;
  logic [2:0]       bitcnt_q;
  logic [1:0]       data_bits_q;
  logic             stop2_q;
  logic             stop_second_q;
  logic             tx_q;
  logic             busy_q;

  logic bit_end;
  logic last_data;
  logic frame_end;
  logic pop;
  logic unused_ok;

  assign bit_end   = (cnt_q == '0);
  assign last_data = (bitcnt_q == ({1'b0, data_bits_q} + 3'd4));
  assign frame_end = (state_q == ST_STOP) && bit_end && (!stop2_q || stop_second_q);
  // Gated by reset so no pop can escape while the engine is held in reset.
  assign pop       = i_nrst && i_enable && i_fifo_valid && ((state_q == ST_IDLE) || frame_end);

  assign o_fifo_rd_req = pop;
  assign o_tx_done     = frame_end;
  assign o_tx          = tx_q;
  assign o_busy        = busy_q;

  assign unused_ok = ^{i_parity_en, i_parity_odd, i_fifo_data};

`ifdef UART_TX_PARITY_EN
  logic [7:0] par_mask;
  logic       par_bit_d;
  logic       par_bit_q;
  logic       par_en_q;

  // Parity covers only the N transmitted bits, so mask off the unsent upper bits.
  assign par_mask  = 8'hFF >> (2'd3 - i_data_bits);
  assign par_bit_d = (^(i_fifo_data[7:0] & par_mask)) ^ i_parity_odd;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else if (pop) begin
      par_bit_q <= par_bit_d;
      par_en_q  <= i_parity_en;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      shift_q       <= '0;
      bitcnt_q      <= '0;
      data_bits_q   <= '0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      if ((state_q != ST_IDLE) && !bit_end) begin
        cnt_q <= cnt_q - CNT_ONE;
      end

      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        ST_START: begin
          if (bit_end) begin
            state_q  <= ST_DATA;
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
            bitcnt_q <= '0;
            cnt_q    <= div_q;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= div_q;
            if (last_data) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q <= ST_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q       <= ST_STOP;
                tx_q          <= 1'b1;
                stop_second_q <= 1'b0;
              end
`else
              state_q       <= ST_STOP;
              tx_q          <= 1'b1;
              stop_second_q <= 1'b0;
`endif
            end else begin
              tx_q     <= shift_q[0];
              shift_q  <= shift_q >> 1;
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_q       <= ST_STOP;
            tx_q          <= 1'b1;
            stop_second_q <= 1'b0;
            cnt_q         <= div_q;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (!frame_end) begin
              stop_second_q <= 1'b1;
              cnt_q         <= div_q;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

      // A pop overrides the above: config is captured here and nowhere else.
      if (pop) begin
        state_q     <= ST_START;
        tx_q        <= 1'b0;
        busy_q      <= 1'b1;
        cnt_q       <= i_baud_div;
        div_q       <= i_baud_div;
        shift_q     <= i_fifo_data[7:0];
        data_bits_q <= i_data_bits;
        stop2_q     <= i_stop2;
      end
    end
  end

endmodule
